wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Writeback-stage consumer for the MEM/WB pipeline register outputs of the 5-stage RV32I pipeline. It selects the writeback result, commits it to the 32x32 integer register file, and serves the two decode-stage read ports with W->D bypass. It also keeps a retired-instruction counter. It sits between the MEM/WB register and the IF/ID-to-ID/EX datapath.

Parameters:
XLEN, 32, datapath and register width
NREGS, 32, number of architectural registers; index width is log2(NREGS)=5
CNTW, 64, retired-instruction counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, synchronous, active-low
RegWriteW  in  1  register write enable from MEM/WB
ResultSrcW  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved
RdW  in  5  destination register
ALUResultW  in  XLEN  ALU result
ReadDataW  in  XLEN  load data
PCPlus4W  in  XLEN  link address
InstrValidW  in  1  real instruction in W; 0 for bubble or flushed slot
Rs1D  in  5  decode read address 1
Rs2D  in  5  decode read address 2
RD1D  out  XLEN  read data 1
RD2D  out  XLEN  read data 2
ResultW  out  XLEN  selected writeback value, also the forwarding source for the hazard unit
InstRetW  out  CNTW  retired-instruction count

Behaviour:
- Only one clock is used. Reset is synchronous and active-low. The clock port is clk and the reset port is rst_n.
- ResultW is combinational:
  - 00 -> ALUResultW
  - 01 -> ReadDataW
  - 10 -> PCPlus4W
  - 11 -> 0
- Register write:
  - At posedge clk, when rst_n=1, RegWriteW=1 and RdW!=0: regs[RdW] <= ResultW.
  - A write to x0 is discarded.
  - The write is independent of InstrValidW. The pipeline clears RegWriteW for bubbles.
- Reads are combinational, with priority in this order:
  - Rs==0 -> 0.
  - Else if rst_n=1, RegWriteW=1 and RdW==Rs -> ResultW. This is same-cycle bypass and replaces negedge-write semantics.
  - Else regs[Rs].
  - Both ports apply the rule independently, and both may bypass in the same cycle.
- Reset:
  - At posedge clk with rst_n=0, all regs and InstRetW are cleared to 0.
  - Writes and counter increment are suppressed in that cycle.
  - While rst_n=0, the bypass is disabled, so RD1D and RD2D reflect the register contents, which are 0 after the first reset edge.
  - Reset asserted mid-stream drops the in-flight W write.
- Counter:
  - At posedge clk with rst_n=1 and InstrValidW=1: InstRetW <= InstRetW+1, modulo 2^CNTW.
  - All-ones wraps to 0 with no flag.
- Latency:
  - A value written at edge N is visible from regs in cycle N+1.
  - In cycle N itself it is visible through the bypass.
  - InstRetW updates one cycle after retirement.
- ResultSrcW=11 with RegWriteW=1 writes 0. This is legal and is not flagged.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN.
  - ResultSrc encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10.
  - The register-index width.
- Sub-module regfile_core holds the storage array, the x0 handling and the two read ports with bypass.
- wb_regfile holds the result mux and the counter.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with RegWriteW=1, RdW=5, ALUResultW=0xDEAD. Then Rs1D=5 -> RD1D=0 and InstRetW=0.
- Mux and write: apply each of the following with RegWriteW=1, RdW=3, then read Rs1D=3 next cycle:
  - ResultSrcW=00, ALUResultW=0x11 -> RD1D=0x11.
  - ResultSrcW=01, ReadDataW=0x22 -> RD1D=0x22.
  - ResultSrcW=10, PCPlus4W=0x104 -> RD1D=0x104.
- Bypass: regs[7]=0xAAAA. In one cycle drive RegWriteW=1, RdW=7, ALUResultW=0x5555, Rs1D=Rs2D=7 -> RD1D=RD2D=0x5555 in that same cycle.
- x0: RegWriteW=1, RdW=0, ALUResultW=0xFFFF_FFFF; Rs1D=0 in the same cycle and in the next cycle -> RD1D=0 both times.
- Counter: drive InstrValidW pattern 1,0,1,1 over 4 cycles -> InstRetW=3. Force the counter to 0xFFFF_FFFF_FFFF_FFFF, then one valid cycle -> InstRetW=0.
- Mid-stream reset: regs[4]=0x1234, then rst_n=0 for one cycle together with RegWriteW=1, RdW=4 -> after release, RD1D(Rs1D=4)=0 and InstRetW=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath width, register index width
// and writeback result-select encodings.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = $clog2(NREGS);

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } result_src_e;

endpackage

// File: rtl/regfile_core.sv
// Integer register file storage with hardwired x0 and two combinational
// read ports that bypass the same-cycle write.
module regfile_core
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_waddr,
    input  logic [XLEN-1:0]          i_wdata,
    input  logic [$clog2(NREGS)-1:0] i_raddr1,
    input  logic [$clog2(NREGS)-1:0] i_raddr2,
    output logic [XLEN-1:0]          o_rdata1,
    output logic [XLEN-1:0]          o_rdata2
);

    localparam int IDXW = $clog2(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wrEn;
    logic            w_bypass1;
    logic            w_bypass2;

    // Writes to x0 are dropped here so the storage for entry 0 stays zero.
    assign w_wrEn = i_we && (i_waddr != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrEn) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Bypass is gated by reset so a write that will be dropped is never seen.
    assign w_bypass1 = rst_n && i_we && (i_waddr == i_raddr1);
    assign w_bypass2 = rst_n && i_we && (i_waddr == i_raddr2);

    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        if (i_raddr1 == IDXW'(0)) begin
            o_rdata1 = '0;
        end else if (w_bypass1) begin
            o_rdata1 = i_wdata;
        end
    end

    always_comb begin
        o_rdata2 = r_regs[i_raddr2];
        if (i_raddr2 == IDXW'(0)) begin
            o_rdata2 = '0;
        end else if (w_bypass2) begin
            o_rdata2 = i_wdata;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the result from MEM/WB, commits it to the register
// file, serves the decode read ports and counts retired instructions.
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS,
    parameter int CNTW  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     RegWriteW,
    input  logic [1:0]               ResultSrcW,
    input  logic [$clog2(NREGS)-1:0] RdW,
    input  logic [XLEN-1:0]          ALUResultW,
    input  logic [XLEN-1:0]          ReadDataW,
    input  logic [XLEN-1:0]          PCPlus4W,
    input  logic                     InstrValidW,
    input  logic [$clog2(NREGS)-1:0] Rs1D,
    input  logic [$clog2(NREGS)-1:0] Rs2D,
    output logic [XLEN-1:0]          RD1D,
    output logic [XLEN-1:0]          RD2D,
    output logic [XLEN-1:0]          ResultW,
    output logic [CNTW-1:0]          InstRetW
);

    logic [CNTW-1:0] r_instRet;
    logic [XLEN-1:0] w_result;

    // The reserved encoding yields zero; committing it is legal.
    always_comb begin
        w_result = '0;
        case (result_src_e'(ResultSrcW))
            RES_ALU: w_result = ALUResultW;
            RES_MEM: w_result = ReadDataW;
            RES_PC4: w_result = PCPlus4W;
            default: w_result = '0;
        endcase
    end

    assign ResultW = w_result;

    regfile_core #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (RegWriteW),
        .i_waddr  (RdW),
        .i_wdata  (w_result),
        .i_raddr1 (Rs1D),
        .i_raddr2 (Rs2D),
        .o_rdata1 (RD1D),
        .o_rdata2 (RD2D)
    );

    // Free-running modulo counter; wraps silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instRet <= '0;
        end else if (InstrValidW) begin
            r_instRet <= r_instRet + CNTW'(1);
        end
    end

    assign InstRetW = r_instRet;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, result mux, write,
// bypass, x0, retire counter with wrap, and mid-stream reset.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic        InstrValidW;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ResultW;
    logic [63:0] InstRetW;

    int assertCount = 0;
    int failCount   = 0;

    wb_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RdW         (RdW),
        .ALUResultW  (ALUResultW),
        .ReadDataW   (ReadDataW),
        .PCPlus4W    (PCPlus4W),
        .InstrValidW (InstrValidW),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .ResultW     (ResultW),
        .InstRetW    (InstRetW)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; RegWriteW = 1'b1; RdW = 5'd5; ResultSrcW = 2'b00;
        ALUResultW = 32'hDEAD; InstrValidW = 1'b1; Rs1D = 5'd5;
        @(negedge clk);
        @(negedge clk);
        #1;
        assertCount++;
        if (RD1D !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL reset_rd1_during: got %h expected %h", RD1D, 32'h0);
        end
        assertCount++;
        if (InstRetW !== 64'h0) begin
            failCount++;
            $display("[TB] FAIL reset_instret_during: got %h expected %h", InstRetW, 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1; RegWriteW = 1'b0; InstrValidW = 1'b0;
        #1;
        assertCount++;
        if (RD1D !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL reset_rd1_after: got %h expected %h", RD1D, 32'h0);
        end
        assertCount++;
        if (InstRetW !== 64'h0) begin
            failCount++;
            $display("[TB] FAIL reset_instret_after: got %h expected %h", InstRetW, 64'h0);
        end
    endtask

    task automatic test_mux_write();
        logic [1:0]  srcs [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [31:0] expv [4] = '{32'h11, 32'h22, 32'h104, 32'h0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            RegWriteW = 1'b1; RdW = 5'd3; ResultSrcW = srcs[i];
            ALUResultW = 32'h11; ReadDataW = 32'h22; PCPlus4W = 32'h104;
            Rs1D = 5'd1;
            #1;
            assertCount++;
            if (ResultW !== expv[i]) begin
                failCount++;
                $display("[TB] FAIL mux_result[%0d]: got %h expected %h", i, ResultW, expv[i]);
            end
            @(negedge clk);
            RegWriteW = 1'b0; Rs1D = 5'd3;
            #1;
            assertCount++;
            if (RD1D !== expv[i]) begin
                failCount++;
                $display("[TB] FAIL mux_write_rd1[%0d]: got %h expected %h", i, RD1D, expv[i]);
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd7; ResultSrcW = 2'b00; ALUResultW = 32'hAAAA;
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 7; ALUResultW = 32'h5555; Rs1D = 5'd7; Rs2D = 5'd7;
        #1;
        assertCount++;
        if (RD1D !== 32'h5555) begin
            failCount++;
            $display("[TB] FAIL bypass_rd1: got %h expected %h", RD1D, 32'h5555);
        end
        assertCount++;
        if (RD2D !== 32'h5555) begin
            failCount++;
            $display("[TB] FAIL bypass_rd2: got %h expected %h", RD2D, 32'h5555);
        end
        @(negedge clk);
        RegWriteW = 1'b0; ALUResultW = 32'h0;
        #1;
        assertCount++;
        if (RD2D !== 32'h5555) begin
            failCount++;
            $display("[TB] FAIL bypass_commit_rd2: got %h expected %h", RD2D, 32'h5555);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd0; ResultSrcW = 2'b00;
        ALUResultW = 32'hFFFF_FFFF; Rs1D = 5'd0; Rs2D = 5'd7;
        #1;
        assertCount++;
        if (RD1D !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL x0_same_cycle: got %h expected %h", RD1D, 32'h0);
        end
        assertCount++;
        if (RD2D !== 32'h5555) begin
            failCount++;
            $display("[TB] FAIL x0_other_port: got %h expected %h", RD2D, 32'h5555);
        end
        @(negedge clk);
        RegWriteW = 1'b0;
        #1;
        assertCount++;
        if (RD1D !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL x0_next_cycle: got %h expected %h", RD1D, 32'h0);
        end
    endtask

    task automatic test_counter();
        logic pattern [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            InstrValidW = pattern[i];
        end
        @(negedge clk);
        InstrValidW = 1'b0;
        #1;
        assertCount++;
        if (InstRetW !== 64'd3) begin
            failCount++;
            $display("[TB] FAIL counter_pattern: got %0d expected %0d", InstRetW, 3);
        end
    endtask

    task automatic test_counter_wrap();
        @(negedge clk);
        force dut.r_instRet = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instRet;
        InstrValidW = 1'b1;
        #1;
        assertCount++;
        if (InstRetW !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failCount++;
            $display("[TB] FAIL counter_preload: got %h expected %h", InstRetW, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        @(negedge clk);
        InstrValidW = 1'b0;
        #1;
        assertCount++;
        if (InstRetW !== 64'h0) begin
            failCount++;
            $display("[TB] FAIL counter_wrap: got %h expected %h", InstRetW, 64'h0);
        end
    endtask

    task automatic test_midstream_reset();
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd4; ResultSrcW = 2'b00; ALUResultW = 32'h1234;
        InstrValidW = 1'b1;
        @(negedge clk);
        RegWriteW = 1'b0; InstrValidW = 1'b0; Rs1D = 5'd4;
        #1;
        assertCount++;
        if (RD1D !== 32'h1234) begin
            failCount++;
            $display("[TB] FAIL midrst_preload: got %h expected %h", RD1D, 32'h1234);
        end
        @(negedge clk);
        rst_n = 1'b0; RegWriteW = 1'b1; RdW = 5'd4; ALUResultW = 32'h9999;
        InstrValidW = 1'b1;
        #1;
        assertCount++;
        if (RD1D !== 32'h1234) begin
            failCount++;
            $display("[TB] FAIL midrst_no_bypass: got %h expected %h", RD1D, 32'h1234);
        end
        @(negedge clk);
        rst_n = 1'b1; RegWriteW = 1'b0; InstrValidW = 1'b0;
        #1;
        assertCount++;
        if (RD1D !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL midrst_rd1: got %h expected %h", RD1D, 32'h0);
        end
        assertCount++;
        if (InstRetW !== 64'h0) begin
            failCount++;
            $display("[TB] FAIL midrst_instret: got %h expected %h", InstRetW, 64'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0; RegWriteW = 1'b0; ResultSrcW = 2'b00; RdW = 5'd0;
        ALUResultW = 32'h0; ReadDataW = 32'h0; PCPlus4W = 32'h0;
        InstrValidW = 1'b0; Rs1D = 5'd0; Rs2D = 5'd0;
        test_reset();
        test_mux_write();
        test_bypass();
        test_x0();
        test_counter();
        test_counter_wrap();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
